dbg_uart_rx: RTL
================

# dbg_uart_rx

Serial receive front end of the debug port: recovers 8N1 UART frames from the external `i_rx` pin and pushes each received byte into the debug RX byte FIFO. The debug command engine pops that FIFO as its command, address and data stream. The block checks the start bit, stop bit and, optionally, parity. It reports framing, overrun and parity errors as single-cycle pulses for the debug status register.

## Interface
- `CLKS_PER_BIT`, default 868: `i_clk` cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity; only used when parity is compiled in.
- `i_clk` input 1: sole clock.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_rx` input 1: asynchronous serial line; idles high.
- `i_fifo_full` input 1: RX FIFO cannot accept a byte this cycle.
- `o_fifo_write` output 1: one-cycle push strobe.
- `o_fifo_wdata` output 8: received byte; 8'h00 whenever `o_fifo_write` is low.
- `o_busy` output 1: high in any state other than IDLE.
- `o_frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `o_overrun` output 1: one-cycle pulse when a valid byte is dropped because the FIFO is full.
- `o_parity_err` output 1: one-cycle pulse on a parity mismatch; constant 0 when parity is compiled out.

## Operation
- `i_rx` passes through a 2-flop synchronizer; both flops reset to 1. `rx_s` is the synchronizer output.
- Bit counter `cnt` has width $clog2(CLKS_PER_BIT). `HALF = CLKS_PER_BIT/2`, using integer division.
- States and transitions:
  - IDLE: `rx_s == 0` → START, `cnt` = 0.
  - START: at `cnt == HALF-1`, sample the line. If 0 → DATA, `cnt` = 0, bit index = 0. If 1 → IDLE; this is a glitch, with no pulse and no push.
  - DATA: at `cnt == CLKS_PER_BIT-1`, shift `rx_s` into the shift register LSB first, clear `cnt`, and increment the bit index. After bit 7 → PARITY if compiled in, else STOP.
  - PARITY: at `cnt == CLKS_PER_BIT-1`, sample the parity bit and store the mismatch flag → STOP.
  - STOP: at `cnt == CLKS_PER_BIT-1`, sample the stop bit and resolve the frame:
    - Stop bit 0 → `o_frame_err`, byte dropped, go to WAIT_HIGH.
    - Stop bit 1 with parity mismatch → `o_parity_err`, byte dropped, go to IDLE.
    - Stop bit 1 with `i_fifo_full` high → `o_overrun`, byte dropped, go to IDLE.
    - Otherwise → push the byte, go to IDLE.
  - WAIT_HIGH: stay until `rx_s == 1`, then → IDLE. This prevents a break condition from being decoded as a stream of 8'h00 frames.
- A frame raises exactly one outcome: push, `o_frame_err`, `o_parity_err` or `o_overrun`. Priority is frame > parity > overrun.
- `i_fifo_full` is sampled only in the stop-sample cycle. The FIFO is never written while full.
- No backpressure exists toward the line. A dropped byte is lost.

## Timing
- Reset values:
  - `o_fifo_write`, `o_busy`, `o_frame_err`, `o_overrun`, `o_parity_err` = 0.
  - `o_fifo_wdata` = 8'h00.
  - State = IDLE, `cnt` = 0, synchronizer = 1.
- Reset asserted mid-frame aborts the frame in the next cycle. No pulse or push is produced for that frame.
- Let d be the first cycle in which IDLE sees `rx_s == 0`; this is 2–3 cycles after the pin edge.
- Sample points relative to d:
  - Start sample: d+HALF.
  - Data bit i: d+HALF+(i+1)·CLKS_PER_BIT.
  - Stop sample: d+HALF+9·CLKS_PER_BIT, or +10·CLKS_PER_BIT with parity.
- All pulses and `o_fifo_write` are registered and assert in the cycle after the stop sample, for exactly 1 cycle.
- `o_busy` falls in that same cycle, except after a framing error.
- A new start bit is detected as early as the cycle after returning to IDLE. Back-to-back frames at full line rate never lose a byte.

## Configuration
- `DBG_UART_RX_PARITY_EN` defined: the PARITY state exists and frames are 8 data bits + parity + stop. Parity sense is set by `PARITY_ODD`.
- `DBG_UART_RX_PARITY_EN` undefined: the PARITY state and parity logic are absent, frames are 8N1, and `o_parity_err` is tied to 0. The port list is identical in both builds.

## Structure
- `dbg_uart_pkg`: holds the state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH) and the default `CLKS_PER_BIT` constant. The matching TX block shares this package.
- Sub-module `dbg_sync2`: a generic 2-flop synchronizer with a reset value parameter. It is instantiated once here for `i_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
- Send 8'hA5 as 8N1 → one `o_fifo_write` with `o_fifo_wdata` = 8'hA5 at cycle d+8+144+1; no error pulses.
- Send 8'h00, 8'hFF, 8'h3C back-to-back with no idle gap → three pushes in order, none lost.
- Drive a 4-cycle low glitch on `i_rx` → no push, no pulse, `o_busy` back to 0 within HALF+2 cycles.
- Send 8'h55 with the stop bit low, then hold the line low for 40 bits → exactly one `o_frame_err`, no push, `o_busy` high until the line returns high.
- Send 8'h12 with `i_fifo_full` = 1 at the stop sample → one `o_overrun`, `o_fifo_write` stays 0. Send 8'h34 with the FIFO no longer full → pushes 8'h34.
- With `DBG_UART_RX_PARITY_EN` and even parity: send 8'h07 with parity bit 0 → `o_parity_err`, no push. Send 8'h07 with parity bit 1 → pushes 8'h07. Also assert `i_rst` mid-DATA → no push, no pulse, and the next frame is received correctly.

Source files
------------

// File: rtl/dbg_uart_pkg.sv
// Shared types and constants for the debug UART receive/transmit pair.
// Holds the line-state enum and the default bit period.
package dbg_uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  function automatic logic par_mismatch(
    input logic [7:0] d,
    input logic       p,
    input logic       odd
  );
    return (^{d, p}) != odd;
  endfunction

endpackage

// File: rtl/dbg_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input.
// Both flops load RST_VAL on synchronous reset.
module dbg_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], i_d};
    end
  end

  assign o_q = sync_q[1];

endmodule

// File: rtl/dbg_uart_rx.sv
// Debug-port UART receiver: 8N1 frames into the RX byte FIFO.
// Define DBG_UART_RX_PARITY_EN to add a parity bit (sense: PARITY_ODD).
module dbg_uart_rx
  import dbg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_fifo_full,
  output logic       o_fifo_write,
  output logic [7:0] o_fifo_wdata,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic rx_s;

  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          wr_q, wr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

`ifdef DBG_UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
  logic perr_q, perr_d;
  logic pe_q, pe_d;
`else
  logic unused_par_odd;
  assign unused_par_odd = 1'(PARITY_ODD);
`endif

  dbg_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    idx_d   = idx_q;
    sh_d    = sh_q;
    wr_d    = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef DBG_UART_RX_PARITY_EN
    perr_d  = perr_q;
    pe_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          // High at mid-start is a glitch.
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef DBG_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef DBG_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          perr_d  = par_mismatch(sh_q, rx_s, PAR_ODD);
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
`ifdef DBG_UART_RX_PARITY_EN
          else if (perr_q) pe_d = 1'b1;
`endif
          else if (i_fifo_full) ovr_d = 1'b1;
          else wr_d = 1'b1;
        end
      end
      WAIT_HIGH: begin
        // Hold off until a break releases.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    wdata_d = wr_d ? sh_q : 8'h00;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef DBG_UART_RX_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      perr_q <= 1'b0;
      pe_q   <= 1'b0;
    end else begin
      perr_q <= perr_d;
      pe_q   <= pe_d;
    end
  end
  assign o_parity_err = pe_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_fifo_write = wr_q;
  assign o_fifo_wdata = wdata_q;
  assign o_busy       = (state_q != IDLE);
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;

endmodule
